// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, NOP encoding and pipeline register layouts
package pipeline_pkg;
  localparam int WIDTH = 16;
  localparam int ADDRESSWIDTH = 4;
  localparam int CNTWIDTH = 16;
  localparam logic [WIDTH-1:0] NOP_INSTR = '0;
  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc_plus1;
    logic             valid;
  } if_id_t;
  typedef struct packed {
    logic                    reg_write;
    logic                    mem_to_reg;
    logic                    mem_write;
    logic [ADDRESSWIDTH-1:0] reg1_addr;
    logic [ADDRESSWIDTH-1:0] reg2_addr;
    logic [ADDRESSWIDTH-1:0] write_addr;
    logic [WIDTH-1:0]        data1;
    logic [WIDTH-1:0]        data2;
    logic [WIDTH-1:0]        imm;
    logic                    valid;
  } id_ex_t;
  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc_plus1: '0, valid: 1'b0};
endpackage

// File: rtl/pipe_reg_en_clr.sv
// pipe_reg_en_clr: pipeline register with async reset, enable and sync clear (clear wins)
module pipe_reg_en_clr #(
  parameter type T = logic,
  parameter T CLR_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  T     d,
  output T     q
);
  T q_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else if (clr) q_q <= CLR_VAL;
    else if (en) q_q <= d;
  assign q = q_q;
endmodule

// File: rtl/pipeline_stage_regs.sv
// pipeline_stage_regs: PC, IF/ID and ID/EX registers with branch redirect and saturating stall/flush counters
module pipeline_stage_regs
  import pipeline_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stallF,
  input  logic                    stallD,
  input  logic                    flushE,
  input  logic                    branchTakenE,
  input  logic [WIDTH-1:0]        branchTargetE,
  input  logic [WIDTH-1:0]        instrF,
  input  logic                    regWriteD,
  input  logic                    memToRegD,
  input  logic                    memWriteD,
  input  logic [ADDRESSWIDTH-1:0] reg1ReadAddressD,
  input  logic [ADDRESSWIDTH-1:0] reg2ReadAddressD,
  input  logic [ADDRESSWIDTH-1:0] writeAddressD,
  input  logic [WIDTH-1:0]        data1D,
  input  logic [WIDTH-1:0]        data2D,
  input  logic [WIDTH-1:0]        immD,
  output logic [WIDTH-1:0]        pcF,
  output logic [WIDTH-1:0]        instrD,
  output logic [WIDTH-1:0]        pcPlus1D,
  output logic                    validD,
  output logic                    validE,
  output logic                    writeEnableE,
  output logic                    resultSelectorWBE,
  output logic                    memWriteE,
  output logic [ADDRESSWIDTH-1:0] reg1ReadAddressE,
  output logic [ADDRESSWIDTH-1:0] reg2ReadAddressE,
  output logic [ADDRESSWIDTH-1:0] writeAddressE,
  output logic [WIDTH-1:0]        data1E,
  output logic [WIDTH-1:0]        data2E,
  output logic [WIDTH-1:0]        immE,
  output logic [CNTWIDTH-1:0]     stallCount,
  output logic [CNTWIDTH-1:0]     flushCount
);
  logic [WIDTH-1:0] pc_q, pc_d, pc_plus1;
  logic [CNTWIDTH-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic clear_e;
  if_id_t if_id_d, if_id_q;
  id_ex_t id_ex_d, id_ex_q;
  always_comb begin
    pc_plus1 = pc_q + WIDTH'(1);
    pc_d = stallF ? pc_q : branchTakenE ? branchTargetE : pc_plus1;
    clear_e = flushE | branchTakenE;
    stall_cnt_d = (stallD && !(&stall_cnt_q)) ? stall_cnt_q + CNTWIDTH'(1) : stall_cnt_q;
    flush_cnt_d = (clear_e && !(&flush_cnt_q)) ? flush_cnt_q + CNTWIDTH'(1) : flush_cnt_q;
    if_id_d = '{instr: instrF, pc_plus1: pc_plus1, valid: 1'b1};
    id_ex_d = '{reg_write: regWriteD, mem_to_reg: memToRegD, mem_write: memWriteD,
                reg1_addr: reg1ReadAddressD, reg2_addr: reg2ReadAddressD,
                write_addr: writeAddressD, data1: data1D, data2: data2D, imm: immD,
                valid: if_id_q.valid};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  pipe_reg_en_clr #(.T(if_id_t), .CLR_VAL(IF_ID_BUBBLE)) u_if_id (
    .clk(clk), .rst_n(rst_n), .en(!stallD), .clr(branchTakenE), .d(if_id_d), .q(if_id_q)
  );
  pipe_reg_en_clr #(.T(id_ex_t), .CLR_VAL('0)) u_id_ex (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(clear_e), .d(id_ex_d), .q(id_ex_q)
  );
  assign pcF = pc_q;
  assign instrD = if_id_q.instr;
  assign pcPlus1D = if_id_q.pc_plus1;
  assign validD = if_id_q.valid;
  assign validE = id_ex_q.valid;
  assign writeEnableE = id_ex_q.reg_write;
  assign resultSelectorWBE = id_ex_q.mem_to_reg;
  assign memWriteE = id_ex_q.mem_write;
  assign reg1ReadAddressE = id_ex_q.reg1_addr;
  assign reg2ReadAddressE = id_ex_q.reg2_addr;
  assign writeAddressE = id_ex_q.write_addr;
  assign data1E = id_ex_q.data1;
  assign data2E = id_ex_q.data2;
  assign immE = id_ex_q.imm;
  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_stage_regs.sv
// tb_pipeline_stage_regs: directed self-checking bench for pipeline_stage_regs
module tb_pipeline_stage_regs;
  logic clk = 0, rst_n = 0;
  logic stallF = 0, stallD = 0, flushE = 0, branchTakenE = 0;
  logic [15:0] branchTargetE = 0, instrF = 0;
  logic regWriteD = 0, memToRegD = 0, memWriteD = 0;
  logic [3:0] reg1ReadAddressD = 0, reg2ReadAddressD = 0, writeAddressD = 0;
  logic [15:0] data1D = 0, data2D = 0, immD = 0;
  logic [15:0] pcF, instrD, pcPlus1D, data1E, data2E, immE, stallCount, flushCount;
  logic validD, validE, writeEnableE, resultSelectorWBE, memWriteE;
  logic [3:0] reg1ReadAddressE, reg2ReadAddressE, writeAddressE;
  int n_checks = 0, n_errors = 0;
  always #5 clk = ~clk;
  pipeline_stage_regs dut (
    .clk(clk), .rst_n(rst_n), .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .branchTakenE(branchTakenE), .branchTargetE(branchTargetE), .instrF(instrF),
    .regWriteD(regWriteD), .memToRegD(memToRegD), .memWriteD(memWriteD),
    .reg1ReadAddressD(reg1ReadAddressD), .reg2ReadAddressD(reg2ReadAddressD),
    .writeAddressD(writeAddressD), .data1D(data1D), .data2D(data2D), .immD(immD),
    .pcF(pcF), .instrD(instrD), .pcPlus1D(pcPlus1D), .validD(validD), .validE(validE),
    .writeEnableE(writeEnableE), .resultSelectorWBE(resultSelectorWBE), .memWriteE(memWriteE),
    .reg1ReadAddressE(reg1ReadAddressE), .reg2ReadAddressE(reg2ReadAddressE),
    .writeAddressE(writeAddressE), .data1E(data1E), .data2E(data2E), .immE(immE),
    .stallCount(stallCount), .flushCount(flushCount)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    check("rst_pcF", pcF, 0);
    check("rst_instrD", instrD, 0);
    check("rst_validD", validD, 0);
    check("rst_validE", validE, 0);
    check("rst_counts", {stallCount, flushCount}, 0);
    @(negedge clk);
    rst_n = 1;
    regWriteD = 1; memToRegD = 1; writeAddressD = 3;
    reg1ReadAddressD = 4'h5; reg2ReadAddressD = 4'h6;
    data1D = 16'h1111; data2D = 16'h2222; immD = 16'h0033;
    for (int i = 0; i < 4; i++) begin
      instrF = 16'hA100 + 16'(i);
      step();
    end
    check("run_pcF", pcF, 16'h0004);
    check("run_validD", validD, 1);
    check("run_instrD", instrD, 16'hA103);
    check("run_pcPlus1D", pcPlus1D, 16'h0004);
    check("run_validE", validE, 1);
    check("run_wrAddrE", writeAddressE, 3);
    stallF = 1; stallD = 1; flushE = 1; instrF = 16'hBEEF;
    step();
    check("stall_pcF", pcF, 16'h0004);
    check("stall_instrD", instrD, 16'hA103);
    check("stall_validD", validD, 1);
    check("flushE_bubble", {validE, writeEnableE, resultSelectorWBE, writeAddressE, data1E, immE}, 0);
    check("stall_counts", {stallCount, flushCount}, {16'd1, 16'd1});
    stallF = 0; stallD = 0; flushE = 0; instrF = 16'hA104;
    step();
    check("resume_pcF", pcF, 16'h0005);
    check("resume_instrD", instrD, 16'hA104);
    check("resume_E", {validE, writeEnableE, resultSelectorWBE, writeAddressE, reg1ReadAddressE, reg2ReadAddressE},
          {1'b1, 1'b1, 1'b1, 4'h3, 4'h5, 4'h6});
    check("resume_data", {data1E, data2E, immE}, {16'h1111, 16'h2222, 16'h0033});
    branchTakenE = 1; branchTargetE = 16'h0040; stallD = 1;
    step();
    check("br_pcF", pcF, 16'h0040);
    check("br_D", {validD, instrD, pcPlus1D}, 0);
    check("br_E", {validE, writeEnableE, writeAddressE}, 0);
    check("br_counts", {stallCount, flushCount}, {16'd2, 16'd2});
    branchTakenE = 0; stallD = 0; instrF = 16'hC001;
    step();
    check("post_br_pcF", pcF, 16'h0041);
    check("post_br_D", {validD, instrD, pcPlus1D}, {1'b1, 16'hC001, 16'h0041});
    check("post_br_validE", validE, 0);
    step();
    check("post_br2_validE", validE, 1);
    branchTakenE = 1; branchTargetE = 16'hFFFF;
    step();
    check("to_ffff", pcF, 16'hFFFF);
    branchTakenE = 0;
    step();
    check("wrap_pcF", pcF, 16'h0000);
    check("wrap_pcPlus1D", pcPlus1D, 16'h0000);
    check("wrap_flush", flushCount, 16'd3);
    stallD = 1;
    repeat (65533) @(posedge clk);
    #1;
    check("sat_reach", stallCount, 16'hFFFF);
    step();
    check("sat_hold", stallCount, 16'hFFFF);
    check("sat_flush", flushCount, 16'd3);
    stallD = 0;
    step();
    check("pre_rst_validE", validE, 1);
    #3;
    rst_n = 0;
    #1;
    check("async_rst_pc", pcF, 0);
    check("async_rst_v", {validD, validE, writeEnableE, writeAddressE}, 0);
    check("async_rst_D", {instrD, pcPlus1D}, 0);
    check("async_rst_cnt", {stallCount, flushCount}, 0);
    @(negedge clk);
    rst_n = 1;
    step();
    check("post_rst_pcF", pcF, 16'h0001);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
